// File: rtl/text_pattern_gen.sv
// Character/attribute stream generator for the text console: row, cell and scrolling-row patterns.
// Optional macro TEXT_PATTERN_ATTR_CYCLE_EN cycles the foreground colour per text row.
module text_pattern_gen #(
  parameter int unsigned BIT_WIDTH     = 10,
  parameter int unsigned BIT_HEIGHT    = 10,
  parameter int unsigned CHAR_W_LOG2   = 3,
  parameter int unsigned CHAR_H_LOG2   = 4,
  parameter logic [7:0]  FIRST_CHAR    = 8'h30,
  parameter logic [7:0]  LAST_CHAR     = 8'h7E,
  parameter int unsigned SCROLL_FRAMES = 30,
  parameter logic [7:0]  ATTRIBUTE     = 8'h0F
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  output logic [7:0]            character,
  output logic [7:0]            attribute,
  output logic                  frame_tick
);

  localparam int unsigned     RANGE    = int'(LAST_CHAR) - int'(FIRST_CHAR) + 1;
  localparam logic [8:0]      LAST_IDX = 9'(RANGE - 1);
  localparam int unsigned     FC_W     = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(SCROLL_FRAMES - 1);

  typedef enum logic [1:0] {
    MODE_ROW    = 2'd0,
    MODE_CELL   = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  mode_t                 mode_q, mode_eff;
  logic [FC_W-1:0]       frame_count;
  logic [8:0]            offset, offset_inc, offset_eff;
  logic [8:0]            row_idx, row_idx_next, cell_idx, cell_idx_next;
  logic [8:0]            scroll_sum, scroll_idx, char_idx;
  logic [BIT_HEIGHT-1:0] row, prev_row;
  logic                  fs, cell_edge;

  function automatic logic [8:0] wrap_inc(input logic [8:0] v);
    return (v == LAST_IDX) ? '0 : v + 9'd1;
  endfunction

  // Indices are kept already reduced mod RANGE, so every update is a single compare-and-wrap.
  always_comb begin
    row           = cy >> CHAR_H_LOG2;
    fs            = (cx == '0) && (cy == '0);
    cell_edge     = (cx[CHAR_W_LOG2-1:0] == '0) && (cx != '0);
    offset_inc    = (frame_count == FC_LAST) ? wrap_inc(offset) : offset;
    mode_eff      = fs ? mode_t'(mode) : mode_q;
    offset_eff    = fs ? offset_inc : offset;
    row_idx_next  = fs ? '0 : ((row != prev_row) ? wrap_inc(row_idx) : row_idx);
    cell_idx_next = (cx == '0) ? row_idx_next : (cell_edge ? wrap_inc(cell_idx) : cell_idx);
    scroll_sum    = row_idx_next + offset_eff;
    scroll_idx    = (scroll_sum > LAST_IDX) ? scroll_sum - 9'(RANGE) : scroll_sum;
    case (mode_eff)
      MODE_CELL:   char_idx = cell_idx_next;
      MODE_SCROLL: char_idx = scroll_idx;
      default:     char_idx = row_idx_next;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      character   <= FIRST_CHAR;
      attribute   <= ATTRIBUTE;
      frame_tick  <= 1'b0;
      frame_count <= '0;
      offset      <= '0;
      mode_q      <= MODE_ROW;
      row_idx     <= '0;
      cell_idx    <= '0;
      prev_row    <= '0;
    end else begin
      frame_tick <= fs;
      mode_q     <= mode_eff;
      offset     <= offset_eff;
      if (fs) begin
        frame_count <= (frame_count == FC_LAST) ? '0 : frame_count + 1'b1;
      end
      row_idx   <= row_idx_next;
      cell_idx  <= cell_idx_next;
      prev_row  <= row;
      character <= FIRST_CHAR + 8'(char_idx);
`ifdef TEXT_PATTERN_ATTR_CYCLE_EN
      attribute <= {ATTRIBUTE[7:4], ATTRIBUTE[3:0] + row[3:0]};
`else
      attribute <= ATTRIBUTE;
`endif
    end
  end

endmodule

// File: tb/tb_text_pattern_gen.sv
// Self-checking bench for text_pattern_gen against a direct row/col/offset arithmetic model.
module tb_text_pattern_gen;

  localparam int unsigned BW  = 10;
  localparam int unsigned BH  = 11;
  localparam int unsigned SF  = 2;
  localparam int unsigned RNG = 32'h7E - 32'h30 + 1;
`ifdef TEXT_PATTERN_ATTR_CYCLE_EN
  localparam bit ATTR_CYCLE = 1'b1;
`else
  localparam bit ATTR_CYCLE = 1'b0;
`endif

  logic          clk_pixel = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [BW-1:0] cx = '0;
  logic [BH-1:0] cy = '0;
  logic [7:0]    character, attribute;
  logic          frame_tick;

  text_pattern_gen #(
    .BIT_HEIGHT   (BH),
    .SCROLL_FRAMES(SF)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .mode      (mode),
    .cx        (cx),
    .cy        (cy),
    .character (character),
    .attribute (attribute),
    .frame_tick(frame_tick)
  );

  always #5 clk_pixel = ~clk_pixel;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  m_mode;
  int unsigned m_fs, m_off;
  bit          m_valid;
  logic [7:0]  exp_char, exp_attr, lit;
  logic        exp_tick;

  task automatic model_reset();
    m_mode = 2'd0; m_fs = 0; m_off = 0; m_valid = 1'b0;
  endtask

  // Drive one pixel, predict the registered outputs, and sample 1 time unit after the edge.
  task automatic step(input int unsigned x, input int unsigned y);
    int unsigned row, col, idx;
    cx = BW'(x);
    cy = BH'(y);
    if (x == 0 && y == 0) begin
      m_mode = mode;
      m_fs++;
      m_off = (m_fs / SF) % RNG;
      m_valid = 1'b1;
    end
    row = y >> 4;
    col = x >> 3;
    case (m_mode)
      2'd1:    idx = (row + col) % RNG;
      2'd2:    idx = (row + m_off) % RNG;
      default: idx = row % RNG;
    endcase
    exp_char = 8'(32'h30 + idx);
    exp_attr = ATTR_CYCLE ? {4'h0, 4'(32'd15 + row)} : 8'h0F;
    exp_tick = (x == 0 && y == 0);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = 2'd0;
    model_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      cx = BW'($urandom_range(1, 1023));
      cy = BH'($urandom_range(1, 2047));
      @(posedge clk_pixel); #1;
      checks++;
      if ({character, attribute, frame_tick} !== {8'h30, 8'h0F, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold got %h/%h/%b exp 30/0f/0", character, attribute, frame_tick);
      end
    end
    reset = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      cx = BW'($urandom_range(1, 1023));
      cy = BH'($urandom_range(1, 2047));
      @(posedge clk_pixel); #1;
      checks++;
      if (frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL reset_release_tick got %b exp 0", frame_tick);
      end
    end
    step(0, 0);
    checks++;
    if (frame_tick !== 1'b1 || character !== 8'h30) begin
      failures++;
      $display("FAIL first_fs got tick=%b char=%h exp tick=1 char=30", frame_tick, character);
    end
    step(1, 0);
    checks++;
    if (frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL tick_one_clk got %b exp 0", frame_tick);
    end
  endtask

  task automatic test_mode0();
    mode = 2'd0;
    for (int unsigned r = 0; r < 80; r++) begin
      int unsigned y;
      y = (r == 0) ? 0 : (r == 1) ? 16 : (r == 29) ? 479 : (r == 79) ? 1264 : r * 16 + $urandom_range(0, 15);
      for (int unsigned x = 0; x < 2; x++) begin
        step(x, y);
        if (m_valid) begin
          checks++;
          if ({character, attribute, frame_tick} !== {exp_char, exp_attr, exp_tick}) begin
            failures++;
            $display("FAIL mode0 x=%0d y=%0d got %h/%h/%b exp %h/%h/%b", x, y, character, attribute, frame_tick, exp_char, exp_attr, exp_tick);
          end
        end
        if (x == 0 && (r == 0 || r == 1 || r == 29 || r == 79)) begin
          lit = (r == 1) ? 8'h31 : (r == 29) ? 8'h4D : 8'h30;
          checks++;
          if (character !== lit) begin
            failures++;
            $display("FAIL mode0_row%0d got %h exp %h", r, character, lit);
          end
        end
      end
    end
  endtask

  task automatic test_mode1();
    mode = 2'd1;
    for (int unsigned r = 0; r < 30; r++) begin
      int unsigned y;
      y = (r == 0) ? 0 : (r == 1) ? 16 : r * 16 + $urandom_range(0, 15);
      for (int unsigned x = 0; x < 488; x++) begin
        step(x, y);
        if (m_valid) begin
          checks++;
          if ({character, attribute, frame_tick} !== {exp_char, exp_attr, exp_tick}) begin
            failures++;
            $display("FAIL mode1 x=%0d y=%0d got %h/%h/%b exp %h/%h/%b", x, y, character, attribute, frame_tick, exp_char, exp_attr, exp_tick);
          end
        end
        if ((r == 1 && x == 24) || (r == 29 && (x == 0 || x == 480))) begin
          lit = (r == 1) ? 8'h34 : (x == 0) ? 8'h4D : 8'h3A;
          checks++;
          if (character !== lit) begin
            failures++;
            $display("FAIL mode1_r%0d_x%0d got %h exp %h", r, x, character, lit);
          end
        end
      end
    end
  endtask

  task automatic test_scroll();
    mode = 2'd2;
    reset = 1'b1;
    cx = BW'(5);
    cy = BH'(5);
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    model_reset();
    for (int unsigned f = 1; f <= 160; f++) begin
      for (int unsigned r = 0; r < 3; r++) begin
        int unsigned y;
        y = (r == 0) ? 0 : r * 16 + $urandom_range(0, 15);
        for (int unsigned x = 0; x < 4; x++) begin
          step(x, y);
          if (m_valid) begin
            checks++;
            if ({character, attribute, frame_tick} !== {exp_char, exp_attr, exp_tick}) begin
              failures++;
              $display("FAIL scroll f=%0d x=%0d y=%0d got %h/%h/%b exp %h/%h/%b", f, x, y, character, attribute, frame_tick, exp_char, exp_attr, exp_tick);
            end
          end
          if (x == 0 && r == 0 && (f == 1 || f == 2 || f == 4 || f == 158)) begin
            lit = (f == 2) ? 8'h31 : (f == 4) ? 8'h32 : 8'h30;
            checks++;
            if (character !== lit) begin
              failures++;
              $display("FAIL scroll_frame%0d got %h exp %h", f, character, lit);
            end
          end
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    mode = 2'd0;
    for (int unsigned f = 0; f < 8; f++) begin
      if (f == 2) mode = 2'd2;
      for (int unsigned r = 0; r < 15; r++) begin
        int unsigned y;
        y = (r == 0) ? 0 : (r == 6) ? 100 : (r == 12) ? 200 : r * 16 + $urandom_range(0, 15);
        if (f == 0 && r == 6) mode = 2'd1;
        for (int unsigned x = 0; x < 40; x++) begin
          step(x, y);
          if (m_valid) begin
            checks++;
            if ({character, attribute, frame_tick} !== {exp_char, exp_attr, exp_tick}) begin
              failures++;
              $display("FAIL switch f=%0d x=%0d y=%0d got %h/%h/%b exp %h/%h/%b", f, x, y, character, attribute, frame_tick, exp_char, exp_attr, exp_tick);
            end
          end
          if (x == 24 && ((f == 0 && r == 7) || (f == 1 && r == 1) || (f == 7 && r == 1))) begin
            lit = (f == 0) ? 8'h37 : (f == 1) ? 8'h34 : 8'h31;
            checks++;
            if (character !== lit) begin
              failures++;
              $display("FAIL switch_lit f=%0d got %h exp %h", f, character, lit);
            end
          end
          if (f == 6 && r == 12 && x == 9) begin
            reset = 1'b1;
            #1;
            checks++;
            if ({character, attribute, frame_tick} !== {8'h30, 8'h0F, 1'b0}) begin
              failures++;
              $display("FAIL midframe_reset got %h/%h/%b exp 30/0f/0", character, attribute, frame_tick);
            end
            @(posedge clk_pixel); #1;
            reset = 1'b0;
            model_reset();
          end
        end
      end
    end
  endtask

  task automatic test_attr();
    mode = 2'd0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned x = 0; x < 8; x++) begin
        step(x, r * 16);
        if (m_valid) begin
          checks++;
          if ({character, attribute, frame_tick} !== {exp_char, exp_attr, exp_tick}) begin
            failures++;
            $display("FAIL attr x=%0d r=%0d got %h/%h/%b exp %h/%h/%b", x, r, character, attribute, frame_tick, exp_char, exp_attr, exp_tick);
          end
        end
        if (x == 0 && r < 3) begin
          lit = !ATTR_CYCLE ? 8'h0F : (r == 0) ? 8'h0F : (r == 1) ? 8'h00 : 8'h01;
          checks++;
          if (attribute !== lit) begin
            failures++;
            $display("FAIL attr_row%0d got %h exp %h", r, attribute, lit);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int unsigned f = 0; f < 8; f++) begin
      int unsigned w, nrows, chg;
      w = $urandom_range(9, 80);
      nrows = $urandom_range(3, 20);
      chg = $urandom_range(1, nrows - 1);
      mode = 2'($urandom_range(0, 3));
      for (int unsigned r = 0; r < nrows; r++) begin
        int unsigned y0, y1;
        if (r == chg) mode = 2'($urandom_range(0, 3));
        y0 = (r == 0) ? 0 : r * 16 + $urandom_range(0, 7);
        y1 = y0 + $urandom_range(1, 8);
        for (int unsigned ln = 0; ln < 2; ln++) begin
          for (int unsigned x = 0; x < w; x++) begin
            step(x, (ln == 0) ? y0 : y1);
            if (m_valid) begin
              checks++;
              if ({character, attribute, frame_tick} !== {exp_char, exp_attr, exp_tick}) begin
                failures++;
                $display("FAIL random f=%0d x=%0d y=%0d got %h/%h/%b exp %h/%h/%b", f, x, cy, character, attribute, frame_tick, exp_char, exp_attr, exp_tick);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_scroll();
    test_mode_switch();
    test_attr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
